ram1_bus_ctrl: RTL and testbench

RAM1_BUS_CTRL -- requirements
Module: ram1_bus_ctrl

---
 rtl/ram1_bus_pkg.sv | 28 ++
 rtl/ram1_bus_ctrl_if.sv | 16 +
 rtl/ram1_bus_ctrl_sync_2ff.sv | 19 +
 rtl/ram1_bus_ctrl.sv | 160 ++++++++++++++++
 tb/tb_ram1_bus_ctrl.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ram1_bus_pkg.sv
// Shared definitions for the RAM1/UART bus controller: state encoding,
// UART register addresses, status bit positions and the address decode.
package ram1_bus_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SRAM_RD,
      SRAM_WR,
      UART_RD,
      UART_WR_WAIT,
      UART_WR,
      STAT,
      DONE
   } busState_e;

   localparam logic [15:0] UART_DATA_ADDR = 16'hBF00;
   localparam logic [15:0] UART_STAT_ADDR = 16'hBF01;
   localparam int          TX_READY_BIT   = 0;
   localparam int          RX_READY_BIT   = 1;

   // Any write to the status register falls through STAT as a no-op.
   function automatic busState_e decodeState(input logic [15:0] addr, input logic write);
      if (addr == UART_STAT_ADDR) return STAT;
      if (addr == UART_DATA_ADDR) return write ? UART_WR : UART_RD;
      return write ? SRAM_WR : SRAM_RD;
   endfunction

endpackage

// File: rtl/ram1_bus_ctrl_if.sv
// Requester-side access handshake for ram1_bus_ctrl.
interface ram1_bus_ctrl_if;
   logic        Req;
   logic        ReqWrite;
   logic [15:0] ReqAddr;
   logic [15:0] ReqData;
   logic        Ack;
   logic        Err;
   logic [15:0] RdData;
   logic        Busy;

   modport master (output Req, ReqWrite, ReqAddr, ReqData,
                   input  Ack, Err, RdData, Busy);
   modport slave  (input  Req, ReqWrite, ReqAddr, ReqData,
                   output Ack, Err, RdData, Busy);
endinterface

// File: rtl/ram1_bus_ctrl_sync_2ff.sv
// Two-flop synchronizer for one asynchronous status input.
module sync_2ff (
   input  logic Clk0,
   input  logic Rst,
   input  logic dAsync,
   output logic dSync
);
   logic meta;

   always_ff @(posedge Clk0 or negedge Rst) begin
      if (!Rst) begin
         meta  <= 1'b0;
         dSync <= 1'b0;
      end else begin
         meta  <= dAsync;
         dSync <= meta;
      end
   end
endmodule

// File: rtl/ram1_bus_ctrl.sv
// SRAM / UART bus sequencer sharing the Ram1 data bus.
// Optional macro UART_TX_WAIT_EN: UART writes wait for the transmitter, with timeout.
//
// state        | meaning
// IDLE         | waiting for Req; latches address/data/direction on acceptance
// SRAM_RD      | EN/OE low WAIT_CYCLES+1 cycles, bus captured on the last one
// SRAM_WR      | EN/WE low WAIT_CYCLES+1 cycles, bus driven with write data
// UART_RD      | rdn low WAIT_CYCLES+1 cycles, bus captured on the last one
// UART_WR_WAIT | waiting for tbre_s&tsre_s (UART_TX_WAIT_EN only)
// UART_WR      | wrn low WAIT_CYCLES+1 cycles, bus driven with write data
// STAT         | one cycle, status word sampled into RdData
// DONE         | Ack pulse, back to IDLE
module ram1_bus_ctrl
   import ram1_bus_pkg::*;
#(
   parameter int WAIT_CYCLES = 1,
   parameter int TX_TIMEOUT  = 255
) (
   input  logic             Clk0,
   input  logic             Rst,
   ram1_bus_ctrl_if.slave   bus,
   output logic             Ram1_EN,
   output logic             Ram1_OE,
   output logic             Ram1_WE,
   output logic [17:0]      Ram1_address,
   inout  wire  [15:0]      Ram1_data,
   output logic             rdn,
   output logic             wrn,
   input  logic             data_ready,
   input  logic             tbre,
   input  logic             tsre
);

   busState_e   state, nxt;
   logic [2:0]  cnt;
   logic [15:0] addrQ, dataQ, rdDataQ, statWord;
   logic        writeQ, ackQ, busyQ, driveEn;
   logic        data_ready_s, tbre_s, tsre_s, txReady;
   logic        accept, strobeState, strobeRead;

   sync_2ff uSyncDr   (.Clk0(Clk0), .Rst(Rst), .dAsync(data_ready), .dSync(data_ready_s));
   sync_2ff uSyncTbre (.Clk0(Clk0), .Rst(Rst), .dAsync(tbre),       .dSync(tbre_s));
   sync_2ff uSyncTsre (.Clk0(Clk0), .Rst(Rst), .dAsync(tsre),       .dSync(tsre_s));

   assign txReady     = tbre_s & tsre_s;
   assign accept      = (state == IDLE) && bus.Req;
   assign strobeState = (state == SRAM_RD) || (state == SRAM_WR) ||
                        (state == UART_RD) || (state == UART_WR);
   assign strobeRead  = (state == SRAM_RD) || (state == UART_RD);

   always_comb begin
      statWord               = '0;
      statWord[RX_READY_BIT] = data_ready_s;
      statWord[TX_READY_BIT] = txReady;
   end

`ifdef UART_TX_WAIT_EN
   localparam int TW = $clog2(TX_TIMEOUT + 1);
   logic [TW-1:0] toCnt;
   logic          errQ;
`endif

   always_comb begin
      nxt = state;
      case (state)
         IDLE: begin
            if (bus.Req) begin
               nxt = decodeState(bus.ReqAddr, bus.ReqWrite);
`ifdef UART_TX_WAIT_EN
               if (nxt == UART_WR) nxt = UART_WR_WAIT;
`endif
            end
         end
         SRAM_RD, SRAM_WR, UART_RD, UART_WR: begin
            if (cnt == 3'd0) nxt = DONE;
         end
`ifdef UART_TX_WAIT_EN
         UART_WR_WAIT: begin
            if (txReady)             nxt = UART_WR;
            else if (toCnt == '0)    nxt = DONE;
         end
`endif
         STAT:    nxt = DONE;
         DONE:    nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   // Strobes and bus enable are registered from the next state so they
   // toggle cleanly on the edge; the SRAM write data is held through DONE so
   // WE rises one cycle before the bus is released.
   always_ff @(posedge Clk0 or negedge Rst) begin
      if (!Rst) begin
         state   <= IDLE;
         ackQ    <= 1'b0;
         busyQ   <= 1'b0;
         rdDataQ <= '0;
         Ram1_EN <= 1'b1;
         Ram1_OE <= 1'b1;
         Ram1_WE <= 1'b1;
         rdn     <= 1'b1;
         wrn     <= 1'b1;
         driveEn <= 1'b0;
         addrQ   <= '0;
         dataQ   <= '0;
         writeQ  <= 1'b0;
         cnt     <= '0;
      end else begin
         state   <= nxt;
         ackQ    <= (nxt == DONE);
         busyQ   <= (nxt != IDLE);
         Ram1_EN <= !((nxt == SRAM_RD) || (nxt == SRAM_WR));
         Ram1_OE <= !(nxt == SRAM_RD);
         Ram1_WE <= !(nxt == SRAM_WR);
         rdn     <= !(nxt == UART_RD);
         wrn     <= !(nxt == UART_WR);
         driveEn <= (nxt == SRAM_WR) || (nxt == UART_WR) ||
                    ((state == SRAM_WR) && (nxt == DONE));
         if (accept) begin
            addrQ  <= bus.ReqAddr;
            dataQ  <= bus.ReqData;
            writeQ <= bus.ReqWrite;
            cnt    <= 3'(WAIT_CYCLES);
         end else if (strobeState && (cnt != 3'd0)) begin
            cnt <= cnt - 3'd1;
         end
         if (strobeRead && (cnt == 3'd0))
            rdDataQ <= Ram1_data;
         else if ((state == STAT) && !writeQ)
            rdDataQ <= statWord;
      end
   end

`ifdef UART_TX_WAIT_EN
   always_ff @(posedge Clk0 or negedge Rst) begin
      if (!Rst) begin
         toCnt <= '0;
         errQ  <= 1'b0;
      end else begin
         if (accept)
            toCnt <= TW'(TX_TIMEOUT - 1);
         else if ((state == UART_WR_WAIT) && (toCnt != '0))
            toCnt <= toCnt - TW'(1);
         errQ <= (state == UART_WR_WAIT) && (nxt == DONE);
      end
   end
   assign bus.Err = errQ;
`else
   logic unusedTxTimeout;
   assign unusedTxTimeout = (TX_TIMEOUT != 0);
   assign bus.Err = 1'b0;
`endif

   assign Ram1_data    = driveEn ? dataQ : 16'hzzzz;
   assign Ram1_address = {2'b00, addrQ};
   assign bus.Ack      = ackQ;
   assign bus.Busy     = busyQ;
   assign bus.RdData   = rdDataQ;

endmodule

// File: tb/tb_ram1_bus_ctrl.sv
// Directed plus randomized bench for ram1_bus_ctrl with SRAM/UART device models.
module tb_ram1_bus_ctrl;

   localparam int W  = 1;
   localparam int TO = 20;
`ifdef UART_TX_WAIT_EN
   localparam int TXW = 1;
`else
   localparam int TXW = 0;
`endif

   logic Clk0 = 1'b0;
   logic Rst  = 1'b1;
   always #5 Clk0 = ~Clk0;

   ram1_bus_ctrl_if busIf();
   logic        Ram1_EN, Ram1_OE, Ram1_WE, rdn, wrn;
   logic        data_ready, tbre, tsre;
   logic [17:0] Ram1_address;
   wire  [15:0] Ram1_data;

   logic [15:0] sram [0:65535];
   logic [15:0] uartOut;
   logic [15:0] expMem [int];
   logic [15:0] lastRd;
   int          total = 0;
   int          bad   = 0;
   int          overlapCnt = 0;

   for (genvar i = 0; i < 16; i++) begin : gPull
      pullup (Ram1_data[i]);
   end

   assign Ram1_data = !rdn ? uartOut :
                      ((!Ram1_EN && !Ram1_OE) ? sram[Ram1_address[15:0]] : 16'hzzzz);

   always @(negedge Clk0) begin
      if (Rst && !Ram1_EN && !Ram1_WE) sram[Ram1_address[15:0]] <= Ram1_data;
      if (!Ram1_EN && (!rdn || !wrn)) overlapCnt <= overlapCnt + 1;
   end

   ram1_bus_ctrl #(.WAIT_CYCLES(W), .TX_TIMEOUT(TO)) dut (
      .Clk0(Clk0), .Rst(Rst), .bus(busIf),
      .Ram1_EN(Ram1_EN), .Ram1_OE(Ram1_OE), .Ram1_WE(Ram1_WE),
      .Ram1_address(Ram1_address), .Ram1_data(Ram1_data),
      .rdn(rdn), .wrn(wrn),
      .data_ready(data_ready), .tbre(tbre), .tsre(tsre)
   );

   typedef struct {
      int          lat;
      int          oeLow, weLow, weBad, rdnLow, wrnLow, enLow, busyLow;
      logic        errAck;
      logic [15:0] tx;
   } obs_t;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic settle();
      repeat (3) @(negedge Clk0);
   endtask

   // lat = index of the Ack cycle, counting the cycle after the accepting edge as 1.
   task automatic access(input logic wr, input logic [15:0] addr, input logic [15:0] data,
                         input int dropAt, input int tbreAt, input int budget,
                         input bit keepReq, output obs_t o);
      o = '{default: 0};
      o.tx = 16'h0000;
      busIf.Req = 1'b1; busIf.ReqWrite = wr; busIf.ReqAddr = addr; busIf.ReqData = data;
      for (int k = 1; k <= budget; k++) begin
         @(posedge Clk0);
         @(negedge Clk0);
         if (!Ram1_OE) o.oeLow++;
         if (!Ram1_WE) begin o.weLow++; if (Ram1_data != data) o.weBad++; end
         if (!rdn) o.rdnLow++;
         if (!wrn) begin o.wrnLow++; o.tx = Ram1_data; end
         if (!Ram1_EN) o.enLow++;
         if (!busIf.Busy) o.busyLow++;
         if (k == dropAt) busIf.Req = 1'b0;
         if (k == tbreAt) tbre = 1'b1;
         if (busIf.Ack) begin o.lat = k; o.errAck = busIf.Err; break; end
      end
      if (!keepReq) busIf.Req = 1'b0;
   endtask

   task automatic checkResetState(input string tag);
      check({tag, "_strobes"}, 32'({Ram1_EN, Ram1_OE, Ram1_WE, rdn, wrn}), 32'h1F);
      check({tag, "_ackerrbusy"}, 32'({busIf.Ack, busIf.Err, busIf.Busy}), 32'h0);
      check({tag, "_rddata"}, 32'(busIf.RdData), 32'h0);
      check({tag, "_addr"}, 32'(Ram1_address), 32'h0);
      check({tag, "_busz"}, 32'(Ram1_data), 32'hFFFF);
   endtask

   // Expected behaviour derived from the access type alone.
   task automatic doOp(input logic wr, input logic [15:0] addr, input logic [15:0] data,
                       input string tag);
      obs_t o;
      logic isStat, isUart;
      logic [15:0] expStat;
      int expLat;
      isStat  = (addr == 16'hBF01);
      isUart  = (addr == 16'hBF00);
      expStat = {14'b0, data_ready, tbre & tsre};
      if (isUart && !wr) uartOut = data;
      access(wr, addr, data, 0, 0, 60, 1'b0, o);
      expLat = isStat ? 2 : (W + 2 + ((isUart && wr) ? TXW : 0));
      check({tag, "_lat"}, 32'(o.lat), 32'(expLat));
      check({tag, "_busy"}, 32'(o.busyLow), 32'h0);
      check({tag, "_err"}, 32'(o.errAck), 32'h0);
      if (isStat) begin
         check({tag, "_stat_quiet"}, 32'(o.enLow + o.oeLow + o.weLow + o.rdnLow + o.wrnLow), 32'h0);
         if (!wr) lastRd = expStat;
      end else if (!isUart) begin
         check({tag, "_en"}, 32'(o.enLow), 32'(W + 1));
         if (wr) begin
            check({tag, "_we"}, 32'(o.weLow), 32'(W + 1));
            check({tag, "_wedata"}, 32'(o.weBad), 32'h0);
            check({tag, "_wr_other"}, 32'(o.oeLow + o.rdnLow + o.wrnLow), 32'h0);
            expMem[int'(addr)] = data;
         end else begin
            check({tag, "_oe"}, 32'(o.oeLow), 32'(W + 1));
            check({tag, "_rd_other"}, 32'(o.weLow + o.rdnLow + o.wrnLow), 32'h0);
            lastRd = expMem[int'(addr)];
         end
      end else begin
         check({tag, "_uart_en"}, 32'(o.enLow + o.oeLow + o.weLow), 32'h0);
         if (wr) begin
            check({tag, "_wrn"}, 32'(o.wrnLow), 32'(W + 1));
            check({tag, "_tx"}, 32'(o.tx), 32'(data));
         end else begin
            check({tag, "_rdn"}, 32'(o.rdnLow), 32'(W + 1));
            lastRd = data;
         end
      end
      check({tag, "_rddata"}, 32'(busIf.RdData), 32'(lastRd));
      @(negedge Clk0);
      check({tag, "_ack_pulse"}, 32'({busIf.Ack, busIf.Busy}), 32'h0);
   endtask

   initial begin
      obs_t o;
      int   ackCnt;
      busIf.Req = 1'b0; busIf.ReqWrite = 1'b0; busIf.ReqAddr = '0; busIf.ReqData = '0;
      data_ready = 1'b0; tbre = 1'b0; tsre = 1'b0; uartOut = 16'h0000; lastRd = 16'h0000;
      #2 Rst = 1'b0;
      repeat (3) @(negedge Clk0);
      checkResetState("reset");
      Rst = 1'b1;
      repeat (2) @(negedge Clk0);

      doOp(1'b1, 16'h0040, 16'h1234, "sram_wr40");
      doOp(1'b0, 16'h0040, 16'h0000, "sram_rd40");
      check("sram_rd40_value", 32'(busIf.RdData), 32'h1234);
      for (int i = 0; i < 8; i++) doOp(1'b1, 16'h0010 + 16'(i), 16'($urandom) & 16'h7FFE, "pool_wr");

      data_ready = 1'b1; tbre = 1'b0; tsre = 1'b0; settle();
      doOp(1'b0, 16'hBF01, 16'h0000, "stat_rd");
      check("stat_rd_value", 32'(busIf.RdData), 32'h0002);
      doOp(1'b0, 16'hBF00, 16'h0041, "uart_rd");
      doOp(1'b1, 16'hBF01, 16'hBEEF, "stat_wr");

`ifdef UART_TX_WAIT_EN
      tbre = 1'b0; tsre = 1'b1; settle();
      access(1'b1, 16'hBF00, 16'h00A5, 0, 0, TO + 20, 1'b0, o);
      check("tx_timeout_lat", 32'(o.lat), 32'(TO + 1));
      check("tx_timeout_err", 32'(o.errAck), 32'h1);
      check("tx_timeout_wrn", 32'(o.wrnLow), 32'h0);
      @(negedge Clk0);
      tbre = 1'b0; settle();
      access(1'b1, 16'hBF00, 16'h005A, 0, 10, TO + 20, 1'b0, o);
      check("tx_late_lat", 32'(o.lat), 32'(W + 14));
      check("tx_late_err", 32'(o.errAck), 32'h0);
      check("tx_late_wrn", 32'(o.wrnLow), 32'(W + 1));
      check("tx_late_data", 32'(o.tx), 32'h005A);
      @(negedge Clk0);
`else
      tbre = 1'b0; tsre = 1'b0; settle();
      access(1'b1, 16'hBF00, 16'h00A5, 0, 0, 60, 1'b0, o);
      check("tx_direct_lat", 32'(o.lat), 32'(W + 2));
      check("tx_direct_err", 32'(o.errAck), 32'h0);
      check("tx_direct_wrn", 32'(o.wrnLow), 32'(W + 1));
      check("tx_direct_data", 32'(o.tx), 32'h00A5);
      @(negedge Clk0);
`endif

      access(1'b0, 16'h0010, 16'h0000, 0, 0, 60, 1'b1, o);
      check("b2b_first_lat", 32'(o.lat), 32'(W + 2));
      access(1'b0, 16'h0011, 16'h0000, 0, 0, 60, 1'b0, o);
      check("b2b_second_lat", 32'(o.lat), 32'(W + 3));
      check("b2b_second_data", 32'(busIf.RdData), 32'(expMem[32'h11]));
      lastRd = expMem[32'h11];
      @(negedge Clk0);

      for (int n = 0; n < 20; n++) begin
         int          kind;
         logic        wr;
         logic [15:0] a, d;
         kind = int'($urandom_range(0, 9));
         wr   = 1'($urandom_range(0, 1));
         d    = 16'($urandom);
         if (kind < 5) begin
            a = 16'h0010 + 16'($urandom_range(0, 7));
         end else if (kind < 7) begin
            a = 16'hBF00;
            if (wr) begin tbre = 1'b1; tsre = 1'b1; settle(); end
         end else begin
            a  = 16'hBF01;
            wr = (kind == 9);
            data_ready = 1'($urandom_range(0, 1));
            tbre = 1'($urandom_range(0, 1));
            tsre = 1'($urandom_range(0, 1));
            settle();
         end
         doOp(wr, a, d, "rand");
      end

      access(1'b0, 16'h0012, 16'h0000, 1, 0, 60, 1'b0, o);
      check("drop_lat", 32'(o.lat), 32'(W + 2));
      check("drop_data", 32'(busIf.RdData), 32'(expMem[32'h12]));
      @(negedge Clk0);
      busIf.Req = 1'b1; busIf.ReqWrite = 1'b1; busIf.ReqAddr = 16'h0077; busIf.ReqData = 16'h5A5A;
      @(posedge Clk0);
      @(negedge Clk0);
      check("rst_we_low", 32'(Ram1_WE), 32'h0);
      Rst = 1'b0;
      #1;
      checkResetState("rst_mid");
      busIf.Req = 1'b0;
      ackCnt = 0;
      repeat (3) begin @(negedge Clk0); ackCnt += int'(busIf.Ack); end
      Rst = 1'b1;
      repeat (5) begin @(negedge Clk0); ackCnt += int'(busIf.Ack); end
      check("rst_no_ack", 32'(ackCnt), 32'h0);

      check("en_uart_overlap", 32'(overlapCnt), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
